// File: rtl/spi_mem_ctrl_if.sv
// Request/data handshake between the CPU control unit and the SPI memory controller.
interface spi_mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_cs;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_write, req_cs, req_addr, req_len, wr_data,
    input  req_ready, wr_ready, rd_data, rd_valid, done, err
  );

  modport slave (
    input  req_valid, req_write, req_cs, req_addr, req_len, wr_data,
    output req_ready, wr_ready, rd_data, rd_valid, done, err
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// Mode-0 SPI master for 23LC1024-style memories: READ/WRITE bursts, N chip
// selects and a programmable SCLK half-period; one transaction at a time.
module spi_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int NUM_CS = 2,
  parameter int DIV    = 1,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_ctrl_if.slave     bus,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int          TX_W      = 8 + ADDR_W;
  localparam int          DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;

  if (ADDR_W != 16 && ADDR_W != 24) begin : g_bad_addr_w
    $error("spi_mem_ctrl: ADDR_W must be 16 or 24");
  end
  if (NUM_CS < 1 || NUM_CS > 4) begin : g_bad_num_cs
    $error("spi_mem_ctrl: NUM_CS must be 1..4");
  end
  if (DIV < 1) begin : g_bad_div
    $error("spi_mem_ctrl: DIV must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD} state_t;

  state_t            r_state;
  logic              r_write;
  logic              r_cs_ok;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [4:0]        r_bit_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_phase;
  logic [TX_W-1:0]   r_tx;
  logic [6:0]        r_rx;
  logic              r_sclk;
  logic [NUM_CS-1:0] r_cs_n;
  logic              r_req_ready;
  logic              r_wr_ready;
  logic [7:0]        r_rd_data;
  logic              r_rd_valid;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_shifting;
  logic              w_div_end;
  logic              w_bit_end;
  logic              w_sample;
  logic              w_field_end;
  logic [NUM_CS-1:0] w_cs_n_sel;

  assign w_accept   = (r_state == S_IDLE) && r_req_ready && bus.req_valid;
  assign w_shifting = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_div_end  = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_bit_end  = w_shifting && r_phase && w_div_end;
  assign w_sample   = w_shifting && r_phase && (r_div_cnt == '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_field_end = 1'b0;
    case (r_state)
      S_CMD, S_DATA: w_field_end = (r_bit_cnt == 5'd7);
      S_ADDR:        w_field_end = (r_bit_cnt == 5'(ADDR_W - 1));
      default:       w_field_end = 1'b0;
    endcase
  end

  // An out-of-range index matches no bit, so nothing gets selected.
  always_comb begin
    w_cs_n_sel = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (bus.req_cs == 2'(i)) w_cs_n_sel[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_cs_ok     <= 1'b0;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_phase     <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_sclk      <= 1'b0;
      r_cs_n      <= '1;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rd_data   <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_state     <= S_CMD;
            r_write     <= bus.req_write;
            r_len       <= bus.req_len;
            r_cs_ok     <= (int'(bus.req_cs) < NUM_CS);
            r_cs_n      <= w_cs_n_sel;
            r_tx        <= {(bus.req_write ? CMD_WRITE : CMD_READ), bus.req_addr};
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_div_cnt   <= '0;
            r_phase     <= 1'b0;
            r_sclk      <= 1'b0;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
          if (w_div_end && !r_phase) begin
            r_phase <= 1'b1;
            r_sclk  <= 1'b1;
          end
          if (w_sample && (r_state == S_DATA) && !r_write) begin
            r_rx <= {r_rx[5:0], miso};
            if (r_bit_cnt == 5'd7) begin
              r_rd_data  <= {r_rx, miso};
              r_rd_valid <= 1'b1;
            end
          end
          // The byte MSB is already on mosi through the bypass; keep it there.
          if (r_wr_ready) r_tx <= {bus.wr_data, {ADDR_W{1'b0}}};
          if (w_bit_end) begin
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
            r_tx      <= r_tx << 1;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_field_end) begin
              r_bit_cnt <= '0;
              case (r_state)
                S_CMD:  r_state <= S_ADDR;
                S_ADDR: begin
                  r_state    <= S_DATA;
                  r_wr_ready <= r_write;
                end
                default: begin
                  if (r_byte_cnt == r_len) begin
                    r_state <= S_HOLD;
                  end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    r_wr_ready <= r_write;
                  end
                end
              endcase
            end
          end
        end
        S_HOLD: begin
          r_div_cnt <= r_div_cnt + 1'b1;
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= S_IDLE;
            r_cs_n    <= '1;
            r_done    <= 1'b1;
            r_err     <= !r_cs_ok;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // wr_data is only valid during the wr_ready cycle, which is also the first
  // low cycle of the byte, so its MSB is bypassed straight onto mosi.
  assign mosi          = r_wr_ready ? bus.wr_data[7] : r_tx[TX_W-1];
  assign sclk          = r_sclk;
  assign cs_n          = r_cs_n;
  assign bus.req_ready = r_req_ready;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule
